// File: rtl/fifo_ecc_check_stage_if.sv
// Valid/ready bus and error-report signals between the FIFO read port,
// the ECC check stage and its consumer.
interface fifo_ecc_check_stage_if #(
    parameter int DATA_WIDTH   = 64,
    parameter int PARITY_WIDTH = 7,
    parameter int CNT_WIDTH    = 16
);
    localparam int CODE_WIDTH = DATA_WIDTH + PARITY_WIDTH;

    logic                  in_valid;
    logic                  in_ready;
    logic [CODE_WIDTH-1:0] in_code;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_corrected;
    logic                  out_uncorr;
    logic                  err_clr;
    logic [CNT_WIDTH-1:0]  ce_count;
    logic [CNT_WIDTH-1:0]  ue_count;
    logic                  error_flag;

    modport slave (
        input  in_valid, in_code, out_ready, err_clr,
        output in_ready, out_valid, out_data, out_corrected, out_uncorr,
               ce_count, ue_count, error_flag
    );

    modport master (
        output in_valid, in_code, out_ready, err_clr,
        input  in_ready, out_valid, out_data, out_corrected, out_uncorr,
               ce_count, ue_count, error_flag
    );
endinterface

// File: rtl/fifo_ecc_check_stage.sv
// Two-stage Hamming SEC checker on the FIFO read side: corrects single-bit
// errors, flags uncorrectable syndromes, counts both for the safety monitor.
module fifo_ecc_check_stage #(
    parameter int DATA_WIDTH   = 64,
    parameter int PARITY_WIDTH = 7,
    parameter int CNT_WIDTH    = 16
) (
    input logic                   Clock,
    input logic                   Reset_,
    fifo_ecc_check_stage_if.slave bus
);
    localparam int CODE_WIDTH = DATA_WIDTH + PARITY_WIDTH;
    localparam int CODE_IDX_W = $clog2(CODE_WIDTH);
    localparam int DATA_IDX_W = $clog2(DATA_WIDTH);

    typedef logic [PARITY_WIDTH-1:0] syn_t;

    // Syndrome is the XOR of the 1-based positions of all set bits.
    function automatic syn_t calc_syndrome(input logic [CODE_WIDTH-1:0] code);
        syn_t                  syn;
        logic [CODE_IDX_W-1:0] idx;
        syn = '0;
        for (int p = 1; p <= CODE_WIDTH; p++) begin
            idx = CODE_IDX_W'(p - 1);
            if (code[idx]) begin
                syn = syn ^ syn_t'(p);
            end
        end
        return syn;
    endfunction

    // Data bits occupy every non-power-of-two position in ascending order.
    function automatic logic [DATA_WIDTH-1:0] extract_data(input logic [CODE_WIDTH-1:0] code);
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_IDX_W-1:0] d;
        logic [CODE_IDX_W-1:0] idx;
        data = '0;
        d    = '0;
        for (int p = 1; p <= CODE_WIDTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                idx     = CODE_IDX_W'(p - 1);
                data[d] = code[idx];
                d       = d + 1'b1;
            end
        end
        return data;
    endfunction

    logic                  s1_valid;
    logic [CODE_WIDTH-1:0] s1_code;
    syn_t                  s1_syn;

    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s2_corrected;
    logic                  s2_uncorr;

    logic [CNT_WIDTH-1:0]  ce_count;
    logic [CNT_WIDTH-1:0]  ue_count;
    logic                  error_flag;

    logic                  s1_load;
    logic                  s2_load;
    logic                  out_hs;
    syn_t                  in_syn;

    logic [CODE_WIDTH-1:0] flip_mask;
    logic                  fix_corrected;
    logic                  fix_uncorr;
    logic [DATA_WIDTH-1:0] fix_data;

    assign s2_load = !s2_valid || bus.out_ready;
    assign s1_load = !s1_valid || s2_load;
    assign out_hs  = s2_valid && bus.out_ready;
    assign in_syn  = calc_syndrome(bus.in_code);

    always_comb begin
        flip_mask     = '0;
        fix_corrected = 1'b0;
        fix_uncorr    = 1'b0;
        if (s1_syn != '0) begin
            if (int'(s1_syn) <= CODE_WIDTH) begin
                fix_corrected = 1'b1;
                flip_mask[CODE_IDX_W'(s1_syn - 1'b1)] = 1'b1;
            end else begin
                fix_uncorr = 1'b1;
            end
        end
        fix_data = extract_data(s1_code ^ flip_mask);
    end

    always_ff @(posedge Clock) begin
        if (Reset_) begin
            s1_valid     <= 1'b0;
            s1_code      <= '0;
            s1_syn       <= '0;
            s2_valid     <= 1'b0;
            s2_data      <= '0;
            s2_corrected <= 1'b0;
            s2_uncorr    <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_code <= bus.in_code;
                    s1_syn  <= in_syn;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data      <= fix_data;
                    s2_corrected <= fix_corrected;
                    s2_uncorr    <= fix_uncorr;
                end
            end
        end
    end

    // A clear in the same cycle as a counting handshake wins.
    always_ff @(posedge Clock) begin
        if (Reset_ || bus.err_clr) begin
            ce_count   <= '0;
            ue_count   <= '0;
            error_flag <= 1'b0;
        end else if (out_hs) begin
            if (s2_corrected && (ce_count != '1)) begin
                ce_count <= ce_count + 1'b1;
            end
            if (s2_uncorr && (ue_count != '1)) begin
                ue_count <= ue_count + 1'b1;
            end
            if (s2_uncorr) begin
                error_flag <= 1'b1;
            end
        end
    end

    assign bus.in_ready      = s1_load;
    assign bus.out_valid     = s2_valid;
    assign bus.out_data      = s2_data;
    assign bus.out_corrected = s2_corrected;
    assign bus.out_uncorr    = s2_uncorr;
    assign bus.ce_count      = ce_count;
    assign bus.ue_count      = ue_count;
    assign bus.error_flag    = error_flag;
endmodule

// File: tb/tb_fifo_ecc_check_stage.sv
// Directed bench for fifo_ecc_check_stage: hand-computed codewords, one task
// per scenario, inputs driven and outputs sampled on the falling edge.
module tb_fifo_ecc_check_stage;
    logic Clock = 1'b0;
    logic Reset_;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] exp_ce = '0;
    logic [15:0] exp_ue = '0;
    logic        exp_flag = 1'b0;

    always #5 Clock = ~Clock;

    fifo_ecc_check_stage_if #(.DATA_WIDTH(64), .PARITY_WIDTH(7), .CNT_WIDTH(16)) bus_a ();
    fifo_ecc_check_stage_if #(.DATA_WIDTH(64), .PARITY_WIDTH(7), .CNT_WIDTH(4))  bus_b ();

    fifo_ecc_check_stage #(.DATA_WIDTH(64), .PARITY_WIDTH(7), .CNT_WIDTH(16)) dut_a (
        .Clock (Clock),
        .Reset_(Reset_),
        .bus   (bus_a)
    );

    fifo_ecc_check_stage #(.DATA_WIDTH(64), .PARITY_WIDTH(7), .CNT_WIDTH(4)) dut_b (
        .Clock (Clock),
        .Reset_(Reset_),
        .bus   (bus_b)
    );

    // Single word through an empty pipeline with out_ready high; called on a falling edge.
    task automatic send_word(input string name, input logic [70:0] code,
                             input logic [63:0] exp_data, input logic exp_corr,
                             input logic exp_uncorr);
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.in_code   = code;
        @(negedge Clock);
        bus_a.in_valid = 1'b0;
        bus_a.in_code  = '0;
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency: out_valid=%b one cycle after accept, expected 0", name, bus_a.out_valid);
        end
        @(negedge Clock);
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== exp_data ||
            bus_a.out_corrected !== exp_corr || bus_a.out_uncorr !== exp_uncorr) begin
            errors++;
            $display("FAIL %s_out: valid=%b data=%h corr=%b uncorr=%b, expected valid=1 data=%h corr=%b uncorr=%b",
                     name, bus_a.out_valid, bus_a.out_data, bus_a.out_corrected, bus_a.out_uncorr,
                     exp_data, exp_corr, exp_uncorr);
        end
        if (exp_corr && exp_ce != 16'hFFFF) exp_ce++;
        if (exp_uncorr && exp_ue != 16'hFFFF) exp_ue++;
        if (exp_uncorr) exp_flag = 1'b1;
        @(negedge Clock);
        checks++;
        if (bus_a.ce_count !== exp_ce || bus_a.ue_count !== exp_ue ||
            bus_a.error_flag !== exp_flag || bus_a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_counters: ce=%0d ue=%0d flag=%b valid=%b, expected ce=%0d ue=%0d flag=%b valid=0",
                     name, bus_a.ce_count, bus_a.ue_count, bus_a.error_flag, bus_a.out_valid,
                     exp_ce, exp_ue, exp_flag);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus_a.out_valid, bus_a.out_corrected, bus_a.out_uncorr, bus_a.error_flag} !== 4'b0000 ||
            bus_a.out_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b corr=%b uncorr=%b flag=%b data=%h, expected all 0",
                     bus_a.out_valid, bus_a.out_corrected, bus_a.out_uncorr, bus_a.error_flag, bus_a.out_data);
        end
        checks++;
        if (bus_a.ce_count !== 16'd0 || bus_a.ue_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: ce=%0d ue=%0d, expected 0 0", bus_a.ce_count, bus_a.ue_count);
        end
        checks++;
        if (bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: a=%b b=%b, expected 1 1", bus_a.in_ready, bus_b.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int first_k  = -1;
        int accepted = 0;
        int received = 0;
        bus_a.out_ready = 1'b1;
        bus_a.in_code   = '0;
        for (int k = 0; k < 110; k++) begin
            if (bus_a.out_valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                received++;
                checks++;
                if (bus_a.out_data !== 64'h0 || bus_a.out_corrected !== 1'b0 || bus_a.out_uncorr !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_word%0d: data=%h corr=%b uncorr=%b, expected 0 0 0",
                             received, bus_a.out_data, bus_a.out_corrected, bus_a.out_uncorr);
                end
            end
            bus_a.in_valid = (k < 100);
            #1;
            if (bus_a.in_valid && bus_a.in_ready) accepted++;
            @(negedge Clock);
        end
        bus_a.in_valid = 1'b0;
        checks++;
        if (first_k !== 2) begin
            errors++;
            $display("FAIL b2b_latency: first out_valid at cycle %0d, expected 2", first_k);
        end
        checks++;
        if (accepted !== 100 || received !== 100) begin
            errors++;
            $display("FAIL b2b_throughput: accepted=%0d received=%0d, expected 100 100", accepted, received);
        end
        checks++;
        if (bus_a.ce_count !== 16'd0 || bus_a.ue_count !== 16'd0) begin
            errors++;
            $display("FAIL b2b_counters: ce=%0d ue=%0d, expected 0 0", bus_a.ce_count, bus_a.ue_count);
        end
    endtask

    task automatic test_single_error();
        send_word("pos3",    71'h4,          64'h0, 1'b1, 1'b0);
        send_word("pos71",   71'(1) << 70,   64'h0, 1'b1, 1'b0);
        send_word("pos64",   71'(1) << 63,   64'h0, 1'b1, 1'b0);
        send_word("d3_pos5", 71'h0E,         64'h3, 1'b1, 1'b0);
        send_word("d4_clean", 71'h2A,        64'h4, 1'b0, 1'b0);
    endtask

    task automatic test_uncorrectable();
        send_word("syn72",    (71'(1) << 7) | (71'(1) << 63),          64'h0, 1'b0, 1'b1);
        send_word("syn72_d1", 71'h7 | (71'(1) << 7) | (71'(1) << 63),  64'h1, 1'b0, 1'b1);
        send_word("sticky",   71'h19,                                  64'h2, 1'b0, 1'b0);
        bus_a.err_clr = 1'b1;
        @(negedge Clock);
        bus_a.err_clr = 1'b0;
        exp_ce = '0;
        exp_ue = '0;
        exp_flag = 1'b0;
        checks++;
        if (bus_a.ce_count !== 16'd0 || bus_a.ue_count !== 16'd0 || bus_a.error_flag !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: ce=%0d ue=%0d flag=%b, expected 0 0 0",
                     bus_a.ce_count, bus_a.ue_count, bus_a.error_flag);
        end
    endtask

    task automatic test_backpressure();
        logic [70:0] codes [4];
        logic [63:0] got [$];
        int  sent = 0;
        bit  held_ok = 1'b1;
        codes[0] = 71'h7;
        codes[1] = 71'h19;
        codes[2] = 71'h1E;
        codes[3] = 71'h2A;
        bus_a.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_code  = codes[sent];
            #1;
            if (bus_a.in_ready) sent++;
            @(negedge Clock);
            if (bus_a.out_valid === 1'b1 && bus_a.out_data !== 64'h1) held_ok = 1'b0;
        end
        checks++;
        if (sent !== 2 || bus_a.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_fill: accepted=%0d in_ready=%b, expected 2 0", sent, bus_a.in_ready);
        end
        checks++;
        if (!held_ok || bus_a.out_valid !== 1'b1 || bus_a.out_data !== 64'h1) begin
            errors++;
            $display("FAIL bp_hold: valid=%b data=%h held=%0d, expected 1 %h 1",
                     bus_a.out_valid, bus_a.out_data, held_ok, 64'h1);
        end
        bus_a.out_ready = 1'b1;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_in_ready: in_ready=%b, expected 1", bus_a.in_ready);
        end
        for (int k = 0; k < 20 && got.size() < 4; k++) begin
            if (bus_a.out_valid === 1'b1) got.push_back(bus_a.out_data);
            if (sent < 4) begin
                bus_a.in_valid = 1'b1;
                bus_a.in_code  = codes[sent];
                #1;
                if (bus_a.in_ready) sent++;
            end else begin
                bus_a.in_valid = 1'b0;
            end
            @(negedge Clock);
        end
        bus_a.in_valid = 1'b0;
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("FAIL bp_count: delivered %0d words, expected 4", got.size());
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++;
            if (got[i] !== 64'(i + 1)) begin
                errors++;
                $display("FAIL bp_order%0d: data=%h, expected %h", i, got[i], 64'(i + 1));
            end
        end
        repeat (2) @(negedge Clock);
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_duplicate: out_valid=%b after drain, expected 0", bus_a.out_valid);
        end
    endtask

    task automatic test_saturation();
        bus_b.out_ready = 1'b1;
        bus_b.in_code   = 71'h4;
        for (int k = 0; k < 30; k++) begin
            bus_b.in_valid = (k < 20);
            @(negedge Clock);
        end
        bus_b.in_valid = 1'b0;
        checks++;
        if (bus_b.ce_count !== 4'd15 || bus_b.ue_count !== 4'd0) begin
            errors++;
            $display("FAIL sat_count: ce=%0d ue=%0d, expected 15 0", bus_b.ce_count, bus_b.ue_count);
        end
        bus_b.in_valid = 1'b1;
        @(negedge Clock);
        bus_b.in_valid = 1'b0;
        @(negedge Clock);
        checks++;
        if (bus_b.out_valid !== 1'b1 || bus_b.out_corrected !== 1'b1) begin
            errors++;
            $display("FAIL sat_word: valid=%b corr=%b, expected 1 1", bus_b.out_valid, bus_b.out_corrected);
        end
        bus_b.err_clr = 1'b1;
        @(negedge Clock);
        bus_b.err_clr = 1'b0;
        checks++;
        if (bus_b.ce_count !== 4'd0 || bus_b.error_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear_wins: ce=%0d flag=%b, expected 0 0", bus_b.ce_count, bus_b.error_flag);
        end
        @(negedge Clock);
        checks++;
        if (bus_b.ce_count !== 4'd0 || bus_b.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_after_clear: ce=%0d valid=%b, expected 0 0", bus_b.ce_count, bus_b.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        send_word("pre_reset", 71'h4, 64'h0, 1'b1, 1'b0);
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_code   = 71'h4;
        @(negedge Clock);
        bus_a.in_code = 71'h7;
        @(negedge Clock);
        bus_a.in_valid = 1'b0;
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b0 || bus_a.ce_count !== 16'd1) begin
            errors++;
            $display("FAIL rst_mid_full: valid=%b in_ready=%b ce=%0d, expected 1 0 1",
                     bus_a.out_valid, bus_a.in_ready, bus_a.ce_count);
        end
        bus_a.out_ready = 1'b1;
        Reset_ = 1'b1;
        @(negedge Clock);
        Reset_ = 1'b0;
        exp_ce = '0;
        exp_ue = '0;
        exp_flag = 1'b0;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.ce_count !== 16'd0 || bus_a.ue_count !== 16'd0 ||
            bus_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_state: valid=%b ce=%0d ue=%0d in_ready=%b, expected 0 0 0 1",
                     bus_a.out_valid, bus_a.ce_count, bus_a.ue_count, bus_a.in_ready);
        end
        send_word("post_reset", 71'h19, 64'h2, 1'b0, 1'b0);
    endtask

    initial begin
        Reset_ = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_code = '0; bus_a.out_ready = 1'b0; bus_a.err_clr = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_code = '0; bus_b.out_ready = 1'b0; bus_b.err_clr = 1'b0;
        repeat (3) @(negedge Clock);
        Reset_ = 1'b0;
        @(negedge Clock);
        test_reset();
        test_back_to_back();
        test_single_error();
        test_uncorrectable();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
